// File: rtl/axis_frame_sink_pkg.sv
// Shared types and helpers for the AXI4-Stream frame sink.
package axis_frame_sink_pkg;

    // Receive FSM states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FRAME   = 2'd1,
        S_DISCARD = 2'd2
    } sink_state_e;

    // tready backpressure modes
    typedef enum logic [1:0] {
        BP_ALWAYS = 2'd0,
        BP_ALT    = 2'd1,
        BP_LFSR   = 2'd2,
        BP_NEVER  = 2'd3
    } bp_mode_e;

    localparam int LFSR_W = 16;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register:
    // feedback is the XOR of bits 0, 2, 3 and 5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    // One step of the right-shifting Fibonacci LFSR
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/axis_bp_lfsr.sv
// 16-bit Fibonacci LFSR producing the random tready pattern for BP_LFSR mode.
module axis_bp_lfsr
    import axis_frame_sink_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rand_bit
);

    logic [LFSR_W-1:0] lfsr_r;

    // Shift register: loads the non-zero seed on reset, steps when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else if (en) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign rand_bit = lfsr_r[0];

endmodule

// File: rtl/axis_frame_sink.sv
// AXI4-Stream frame sink: programmable backpressure, framing / length /
// incrementing-data checks, saturating frame counters and sticky error flags.
module axis_frame_sink
    import axis_frame_sink_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                LEN_W     = 16,
    parameter int                CNT_W     = 32,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    input  logic              cfg_en,
    input  logic [1:0]        cfg_bp_mode,
    input  logic [LEN_W-1:0]  cfg_frame_len,
    input  logic              cfg_chk_data,
    input  logic              clr_stats,
    output logic              frame_done,
    output logic [LEN_W-1:0]  last_len,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sof,
    output logic              err_len,
    output logic              err_data
);

    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_MAX   = {LEN_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Saturating increment for the statistics counters
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    // Saturating increment for the per-frame beat counter
    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
        return (v == LEN_MAX) ? v : (v + LEN_ONE);
    endfunction

    bp_mode_e          bp_mode_s;
    logic              lfsr_bit_s;
    logic              tready_r;
    logic              tready_nxt_s;
    logic              acc_s;

    sink_state_e       state_r;
    sink_state_e       state_nxt_s;
    logic [LEN_W-1:0]  beat_idx_r;
    logic [LEN_W-1:0]  beat_idx_nxt_s;
    logic [DATA_W-1:0] exp_data_r;
    logic [DATA_W-1:0] exp_data_nxt_s;
    logic              frame_err_r;
    logic              frame_err_nxt_s;

    logic              end_s;
    logic              ev_sof_s;
    logic              ev_data_s;
    logic              ev_len_s;
    logic              frame_bad_s;
    logic [LEN_W-1:0]  len_final_s;

    logic              frame_done_r;
    logic [LEN_W-1:0]  last_len_r;
    logic [CNT_W-1:0]  frame_cnt_r;
    logic [CNT_W-1:0]  err_cnt_r;
    logic              err_sof_r;
    logic              err_len_r;
    logic              err_data_r;

    assign bp_mode_s = bp_mode_e'(cfg_bp_mode);
    assign acc_s     = s_axis_tvalid & tready_r;

    axis_bp_lfsr #(
        .SEED (LFSR_SEED)
    ) u_bp_lfsr (
        .clk      (aclk),
        .rst_n    (aresetn),
        .en       (1'b1),
        .rand_bit (lfsr_bit_s)
    );

    // Next tready value; independent of tvalid so the sink never waits on the master
    always_comb begin
        tready_nxt_s = 1'b0;
        if (!cfg_en) begin
            tready_nxt_s = 1'b0;
        end else begin
            case (bp_mode_s)
                BP_ALWAYS: tready_nxt_s = 1'b1;
                BP_ALT:    tready_nxt_s = ~tready_r;
                BP_LFSR:   tready_nxt_s = lfsr_bit_s;
                BP_NEVER:  tready_nxt_s = 1'b0;
                default:   tready_nxt_s = 1'b0;
            endcase
        end
    end

    // tready register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tready_r <= 1'b0;
        end else begin
            tready_r <= tready_nxt_s;
        end
    end

    // Receive FSM next state, beat/data tracking and per-beat error events
    always_comb begin
        state_nxt_s     = state_r;
        beat_idx_nxt_s  = beat_idx_r;
        exp_data_nxt_s  = exp_data_r;
        frame_err_nxt_s = frame_err_r;
        end_s           = 1'b0;
        ev_sof_s        = 1'b0;
        ev_data_s       = 1'b0;
        ev_len_s        = 1'b0;
        frame_bad_s     = 1'b0;
        len_final_s     = len_sat_inc(beat_idx_r);

        if (!cfg_en) begin
            // Disabled: drop any partial frame without counting it
            state_nxt_s     = S_IDLE;
            beat_idx_nxt_s  = LEN_ZERO;
            frame_err_nxt_s = 1'b0;
        end else if (acc_s) begin
            case (state_r)
                S_IDLE: begin
                    beat_idx_nxt_s = LEN_ONE;
                    len_final_s    = LEN_ONE;
                    if (s_axis_tuser) begin
                        state_nxt_s     = S_FRAME;
                        exp_data_nxt_s  = s_axis_tdata + DATA_ONE;
                        frame_err_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s     = S_DISCARD;
                        ev_sof_s        = 1'b1;
                        frame_err_nxt_s = 1'b1;
                    end
                end
                S_FRAME: begin
                    beat_idx_nxt_s = len_sat_inc(beat_idx_r);
                    exp_data_nxt_s = exp_data_r + DATA_ONE;
                    if (s_axis_tuser) begin
                        ev_sof_s = 1'b1;
                    end else begin
                        ev_sof_s = 1'b0;
                    end
                    if (cfg_chk_data && (s_axis_tdata != exp_data_r)) begin
                        ev_data_s = 1'b1;
                    end else begin
                        ev_data_s = 1'b0;
                    end
                    if (ev_sof_s || ev_data_s) begin
                        frame_err_nxt_s = 1'b1;
                    end else begin
                        frame_err_nxt_s = frame_err_r;
                    end
                end
                S_DISCARD: begin
                    beat_idx_nxt_s = len_sat_inc(beat_idx_r);
                end
                default: begin
                    state_nxt_s     = S_IDLE;
                    beat_idx_nxt_s  = LEN_ZERO;
                    frame_err_nxt_s = 1'b0;
                end
            endcase

            if (s_axis_tlast) begin
                // Frame ends on this beat whatever state it arrived in
                end_s = 1'b1;
                if ((cfg_frame_len != LEN_ZERO) && (len_final_s != cfg_frame_len)) begin
                    ev_len_s = 1'b1;
                end else begin
                    ev_len_s = 1'b0;
                end
                frame_bad_s     = frame_err_nxt_s | ev_len_s;
                state_nxt_s     = S_IDLE;
                beat_idx_nxt_s  = LEN_ZERO;
                frame_err_nxt_s = 1'b0;
            end else begin
                end_s = 1'b0;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Receive FSM and frame tracking registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= S_IDLE;
            beat_idx_r  <= LEN_ZERO;
            exp_data_r  <= DATA_ZERO;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            beat_idx_r  <= beat_idx_nxt_s;
            exp_data_r  <= exp_data_nxt_s;
            frame_err_r <= frame_err_nxt_s;
        end
    end

    // Frame-end outputs, saturating counters and sticky flags; clr_stats wins
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_done_r <= 1'b0;
            last_len_r   <= LEN_ZERO;
            frame_cnt_r  <= CNT_ZERO;
            err_cnt_r    <= CNT_ZERO;
            err_sof_r    <= 1'b0;
            err_len_r    <= 1'b0;
            err_data_r   <= 1'b0;
        end else begin
            frame_done_r <= end_s;
            if (end_s) begin
                last_len_r <= len_final_s;
            end else begin
                last_len_r <= last_len_r;
            end

            if (clr_stats) begin
                frame_cnt_r <= CNT_ZERO;
                err_cnt_r   <= CNT_ZERO;
                err_sof_r   <= 1'b0;
                err_len_r   <= 1'b0;
                err_data_r  <= 1'b0;
            end else begin
                err_sof_r  <= err_sof_r | ev_sof_s;
                err_len_r  <= err_len_r | ev_len_s;
                err_data_r <= err_data_r | ev_data_s;
                if (end_s && frame_bad_s) begin
                    err_cnt_r <= cnt_sat_inc(err_cnt_r);
                end else if (end_s) begin
                    frame_cnt_r <= cnt_sat_inc(frame_cnt_r);
                end else begin
                    frame_cnt_r <= frame_cnt_r;
                    err_cnt_r   <= err_cnt_r;
                end
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign frame_done    = frame_done_r;
    assign last_len      = last_len_r;
    assign frame_cnt     = frame_cnt_r;
    assign err_cnt       = err_cnt_r;
    assign err_sof       = err_sof_r;
    assign err_len       = err_len_r;
    assign err_data      = err_data_r;

endmodule

// File: tb/tb_axis_frame_sink.sv
// Self-checking bench for axis_frame_sink: randomized master against a
// frame-level reference model, compared every cycle on the falling edge.
module tb_axis_frame_sink;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        cfg_en = 1'b1;
    logic [1:0]  cfg_bp_mode = 2'd0;
    logic [15:0] cfg_frame_len = 16'd8;
    logic        cfg_chk_data = 1'b1;
    logic        clr_stats = 1'b0;
    logic        frame_done;
    logic [15:0] last_len;
    logic [31:0] frame_cnt;
    logic [31:0] err_cnt;
    logic        err_sof;
    logic        err_len;
    logic        err_data;

    always #5 aclk = ~aclk;

    axis_frame_sink dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .cfg_en        (cfg_en),
        .cfg_bp_mode   (cfg_bp_mode),
        .cfg_frame_len (cfg_frame_len),
        .cfg_chk_data  (cfg_chk_data),
        .clr_stats     (clr_stats),
        .frame_done    (frame_done),
        .last_len      (last_len),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .err_sof       (err_sof),
        .err_len       (err_len),
        .err_data      (err_data)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, val, lo, hi);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic        exp_tready, exp_done, exp_sof, exp_len, exp_dat;
    logic [15:0] exp_last_len;
    logic [31:0] exp_fcnt, exp_ecnt;
    logic [15:0] m_lfsr;
    logic [31:0] m_q[$];      // beats of the frame in progress
    logic        m_first_user;
    logic        m_ferr;

    task automatic model_reset();
        exp_tready = 1'b0; exp_done = 1'b0; exp_last_len = 16'd0;
        exp_fcnt = 32'd0; exp_ecnt = 32'd0;
        exp_sof = 1'b0; exp_len = 1'b0; exp_dat = 1'b0;
        m_lfsr = 16'hACE1; m_q.delete(); m_ferr = 1'b0; m_first_user = 1'b0;
    endtask

    task automatic model_step();
        logic acc, nt, ev_len, bad;
        int n;
        logic [15:0] ln;
        acc = s_axis_tvalid && exp_tready;
        if (!cfg_en) nt = 1'b0;
        else begin
            case (int'(cfg_bp_mode))
                0: nt = 1'b1;
                1: nt = !exp_tready;
                2: nt = m_lfsr[0];
                default: nt = 1'b0;
            endcase
        end
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        exp_tready = nt;
        exp_done = 1'b0;
        if (!cfg_en) begin
            m_q.delete();
            m_ferr = 1'b0;
        end else if (acc) begin
            if (m_q.size() == 0) begin
                m_first_user = s_axis_tuser;
                if (!s_axis_tuser) begin m_ferr = 1'b1; exp_sof = 1'b1; end
            end else if (m_first_user) begin
                if (s_axis_tuser) begin m_ferr = 1'b1; exp_sof = 1'b1; end
                if (cfg_chk_data && (s_axis_tdata != m_q[0] + 32'(m_q.size()))) begin
                    m_ferr = 1'b1; exp_dat = 1'b1;
                end
            end
            m_q.push_back(s_axis_tdata);
            if (s_axis_tlast) begin
                n = m_q.size();
                ln = (n > 65535) ? 16'hFFFF : 16'(n);
                ev_len = (cfg_frame_len != 16'd0) && (ln != cfg_frame_len);
                bad = m_ferr || ev_len;
                if (ev_len) exp_len = 1'b1;
                if (bad) exp_ecnt = (exp_ecnt == 32'hFFFFFFFF) ? exp_ecnt : exp_ecnt + 32'd1;
                else     exp_fcnt = (exp_fcnt == 32'hFFFFFFFF) ? exp_fcnt : exp_fcnt + 32'd1;
                exp_done = 1'b1;
                exp_last_len = ln;
                m_q.delete();
                m_ferr = 1'b0;
            end
        end
        if (clr_stats) begin
            exp_fcnt = 32'd0; exp_ecnt = 32'd0;
            exp_sof = 1'b0; exp_len = 1'b0; exp_dat = 1'b0;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;
    int rdy_hi = 0;
    int cyc = 0;
    int done_seen = 0;

    // Compare all outputs against the model on the falling edge
    always @(negedge aclk) begin
        if (cmp_en) begin
            chk("tready", s_axis_tready, exp_tready);
            chk("frame_done", frame_done, exp_done);
            chk("last_len", last_len, exp_last_len);
            chk("frame_cnt", frame_cnt, exp_fcnt);
            chk("err_cnt", err_cnt, exp_ecnt);
            chk("err_sof", err_sof, exp_sof);
            chk("err_len", err_len, exp_len);
            chk("err_data", err_data, exp_dat);
            if (s_axis_tready) rdy_hi++;
            if (frame_done) done_seen++;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    bit clr_rand_en = 1'b0;

    task automatic cycle();
        @(posedge aclk);
        if (aresetn) model_step();
        #1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        clr_stats = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic clr();
        s_axis_tvalid = 1'b0;
        clr_stats = 1'b1;
        cycle();
        clr_stats = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic u, input logic l, input int gap);
        logic rdy;
        int waited;
        repeat (gap) begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata = $urandom;
            s_axis_tuser = 1'($urandom);
            s_axis_tlast = 1'($urandom);
            clr_stats = clr_rand_en && ($urandom_range(0, 15) == 0);
            cycle();
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata = d;
        s_axis_tuser = u;
        s_axis_tlast = l;
        waited = 0;
        forever begin
            clr_stats = clr_rand_en && ($urandom_range(0, 15) == 0);
            rdy = s_axis_tready;
            cycle();
            if (rdy) break;
            waited++;
            if (waited > 500) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout actual=no_tready required=tready_within_500");
                break;
            end
        end
        clr_stats = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] d0, input logic u0,
                              input int bad_idx, input logic [31:0] bad_val, input int maxgap);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = (i == bad_idx) ? bad_val : d0 + 32'(i);
            send_beat(d, (i == 0) ? u0 : 1'b0, (i == n - 1), $urandom_range(0, maxgap));
        end
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        #1;
        aresetn = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        repeat (3) cycle();
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_tready", s_axis_tready, 1'b0);
        aresetn = 1'b1;

        // 1: clean 8-beat frame, always ready
        cfg_bp_mode = 2'd0; cfg_frame_len = 16'd8; cfg_chk_data = 1'b1;
        done_seen = 0;
        send_frame(8, 32'h10, 1'b1, -1, 32'd0, 0);
        idle(3);
        chk("t1_done_pulses", done_seen, 1);
        chk("t1_last_len", last_len, 16'd8);
        chk("t1_frame_cnt", frame_cnt, 32'd1);
        chk("t1_flags", {err_sof, err_len, err_data}, 3'b000);

        // 2: 100 frames of 16 under LFSR backpressure
        clr();
        cfg_bp_mode = 2'd2; cfg_frame_len = 16'd16;
        rdy_hi = 0; cyc = 0;
        for (int f = 0; f < 100; f++) send_frame(16, $urandom, 1'b1, -1, 32'd0, 2);
        idle(3);
        chk("t2_frame_cnt", frame_cnt, 32'd100);
        chk("t2_err_cnt", err_cnt, 32'd0);
        chk_range("t2_tready_duty_pct", (cyc > 0) ? (rdy_hi * 100) / cyc : 0, 30, 70);

        // 3: missing SOF, then a good frame (alternating ready)
        clr();
        cfg_bp_mode = 2'd1; cfg_frame_len = 16'd4;
        send_frame(4, 32'h100, 1'b0, -1, 32'd0, 1);
        idle(3);
        chk("t3_err_sof", err_sof, 1'b1);
        chk("t3_err_cnt", err_cnt, 32'd1);
        chk("t3_frame_cnt0", frame_cnt, 32'd0);
        send_frame(4, 32'h200, 1'b1, -1, 32'd0, 1);
        idle(3);
        chk("t3_frame_cnt1", frame_cnt, 32'd1);

        // 4: short frame, then corrupted beat 3
        clr();
        cfg_bp_mode = 2'd0; cfg_frame_len = 16'd8;
        send_frame(7, 32'h10, 1'b1, -1, 32'd0, 0);
        idle(3);
        chk("t4_err_len", err_len, 1'b1);
        chk("t4_err_data0", err_data, 1'b0);
        chk("t4_last_len", last_len, 16'd7);
        send_frame(8, 32'h10, 1'b1, 3, 32'h99, 0);
        idle(3);
        chk("t4_err_data1", err_data, 1'b1);
        chk("t4_err_cnt", err_cnt, 32'd2);

        // 5: data wrap, then never-ready
        clr();
        cfg_frame_len = 16'd4;
        send_frame(4, 32'hFFFFFFFE, 1'b1, -1, 32'd0, 1);
        idle(3);
        chk("t5_no_err_data", err_data, 1'b0);
        chk("t5_frame_cnt", frame_cnt, 32'd1);
        cfg_bp_mode = 2'd3;
        idle(2);
        rdy_hi = 0;
        s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1; s_axis_tlast = 1'b1;
        repeat (20) cycle();
        s_axis_tvalid = 1'b0;
        chk("t5_never_ready_cycles", rdy_hi, 0);
        chk("t5_frame_cnt_hold", frame_cnt, 32'd1);

        // 6a: reset after beat 3 of 8
        cfg_bp_mode = 2'd0; cfg_frame_len = 16'd8;
        clr();
        for (int i = 0; i < 3; i++) send_beat(32'h30 + 32'(i), (i == 0), 1'b0, 0);
        aresetn = 1'b0;
        model_reset();
        done_seen = 0;
        idle(2);
        chk("t6_rst_frame_cnt", frame_cnt, 32'd0);
        chk("t6_rst_done_pulses", done_seen, 0);
        aresetn = 1'b1;
        send_frame(8, 32'h40, 1'b1, -1, 32'd0, 1);
        idle(3);
        chk("t6_after_rst_frame_cnt", frame_cnt, 32'd1);
        chk("t6_after_rst_done", done_seen, 1);

        // 6b: cfg_en dropped mid-frame
        for (int i = 0; i < 3; i++) send_beat(32'h60 + 32'(i), (i == 0), 1'b0, 0);
        s_axis_tvalid = 1'b0;
        cfg_en = 1'b0;
        idle(3);
        chk("t6_dis_tready", s_axis_tready, 1'b0);
        cfg_en = 1'b1;
        idle(1);
        chk("t6_dis_frame_cnt", frame_cnt, 32'd1);
        chk("t6_dis_err_cnt", err_cnt, 32'd0);
        send_frame(8, 32'h50, 1'b1, -1, 32'd0, 1);
        idle(3);
        chk("t6_en_frame_cnt", frame_cnt, 32'd2);
        chk("t6_en_err_cnt", err_cnt, 32'd0);

        // 7: random mix of modes, lengths, errors and clr_stats collisions
        clr_rand_en = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int n;
            cfg_bp_mode = 2'($urandom_range(0, 2));
            cfg_frame_len = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(3, 6));
            cfg_chk_data = 1'($urandom);
            n = $urandom_range(1, 6);
            send_frame(n, $urandom, ($urandom_range(0, 5) != 0), $urandom_range(0, 8),
                       $urandom, 2);
        end
        clr_rand_en = 1'b0;
        idle(3);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
